// File: rtl/boss_phase_controller.sv
// Boss hit-point / attack-phase controller: frame-rate FSM driving
// hurt blink, death sequencing, shot cadence and missile fan width.
module boss_phase_controller #(
  parameter int LIVES_WIDTH        = 5,
  parameter int LIVES_AMOUNT       = 12,
  parameter int PHASE_COUNT        = 3,
  parameter int CHANNELS           = 8,
  parameter int BASE_COOLDOWN      = 90,
  parameter int COOLDOWN_STEP      = 30,
  parameter int DAMAGE_FRAMES      = 10,
  parameter int DEATH_DELAY_FRAMES = 10,
  localparam int PHW = (PHASE_COUNT > 1) ? $clog2(PHASE_COUNT) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   startOfFrame,
  input  logic                   hit,
  output logic [LIVES_WIDTH-1:0] lives_left,
  output logic [PHW-1:0]         phase,
  output logic                   phase_change,
  output logic                   shoot_pulse,
  output logic [CHANNELS-1:0]    fan_mask,
  output logic                   faded,
  output logic                   boss_dead,
  output logic                   deactivated
);

  localparam int HPP = LIVES_AMOUNT / PHASE_COUNT;
  localparam int HW  = $clog2(DAMAGE_FRAMES + 1);
  localparam int DW  = $clog2(DEATH_DELAY_FRAMES + 1);
  localparam int PCW = $clog2(HPP + 1);
  localparam int CW  = $clog2(BASE_COOLDOWN + 1);

  localparam logic [LIVES_WIDTH-1:0] LIVES_INIT = LIVES_WIDTH'(LIVES_AMOUNT);
  localparam logic [PHW-1:0] PHASE_LAST = PHW'(PHASE_COUNT - 1);
  localparam logic [PCW-1:0] HPP_V      = PCW'(HPP);
  localparam logic [HW-1:0]  HURT_LAST  = HW'(DAMAGE_FRAMES - 1);
  localparam logic [DW-1:0]  DEATH_LAST = DW'(DEATH_DELAY_FRAMES - 1);
  localparam logic [CW-1:0]  CD_INIT    = CW'(BASE_COOLDOWN - 1);

  typedef enum logic [1:0] {
    S_ACTIVE,
    S_HURT,
    S_DYING,
    S_DEAD
  } state_t;

  state_t                 state_q, state_d;
  logic [LIVES_WIDTH-1:0] lives_q, lives_d;
  logic [PHW-1:0]         phase_q, phase_d;
  logic [PCW-1:0]         hip_q, hip_d;
  logic [HW-1:0]          hurt_cnt_q, hurt_cnt_d;
  logic [DW-1:0]          death_cnt_q, death_cnt_d;
  logic [CW-1:0]          cd_q, cd_d;
  logic                   hit_seen_q, hit_seen_d;
  logic                   phase_change_q, phase_change_d;
  logic                   shoot_pulse_q, shoot_pulse_d;
  logic                   tick;
  logic                   hit_any;

  assign tick    = startOfFrame & enable;
  assign hit_any = hit_seen_q | hit;

  always_comb begin
    state_d        = state_q;
    lives_d        = lives_q;
    phase_d        = phase_q;
    hip_d          = hip_q;
    hurt_cnt_d     = hurt_cnt_q;
    death_cnt_d    = death_cnt_q;
    cd_d           = cd_q;
    hit_seen_d     = hit_seen_q;
    phase_change_d = 1'b0;
    shoot_pulse_d  = 1'b0;

    if (tick) begin
      hit_seen_d = 1'b0;
    end else if (hit && enable) begin
      hit_seen_d = 1'b1;
    end

    if (tick) begin
      unique case (state_q)
        S_ACTIVE: begin
          if (hit_any) begin
            if (lives_q != '0) begin
              lives_d = lives_q - 1'b1;
            end
            if (lives_d == '0) begin
              state_d     = S_DYING;
              death_cnt_d = '0;
            end else begin
              state_d    = S_HURT;
              hurt_cnt_d = '0;
              if (hip_q != HPP_V) begin
                hip_d = hip_q + 1'b1;
              end
              if (hip_d == HPP_V && phase_q != PHASE_LAST) begin
                phase_d        = phase_q + 1'b1;
                hip_d          = '0;
                phase_change_d = 1'b1;
              end
            end
          end
        end
        S_HURT: begin
          hurt_cnt_d = hurt_cnt_q + 1'b1;
          if (hurt_cnt_q == HURT_LAST) begin
            state_d = S_ACTIVE;
          end
        end
        S_DYING: begin
          death_cnt_d = death_cnt_q + 1'b1;
          if (death_cnt_q == DEATH_LAST) begin
            state_d = S_DEAD;
          end
        end
        S_DEAD: begin
        end
      endcase

      // the killing tick already counts as dying: no shot, cooldown frozen
      if ((state_q == S_ACTIVE || state_q == S_HURT) &&
          state_d != S_DYING) begin
        if (cd_q == '0) begin
          shoot_pulse_d = 1'b1;
          cd_d = CW'(BASE_COOLDOWN - int'(phase_d) * COOLDOWN_STEP - 1);
        end else begin
          cd_d = cd_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_ACTIVE;
      lives_q        <= LIVES_INIT;
      phase_q        <= '0;
      hip_q          <= '0;
      hurt_cnt_q     <= '0;
      death_cnt_q    <= '0;
      cd_q           <= CD_INIT;
      hit_seen_q     <= 1'b0;
      phase_change_q <= 1'b0;
      shoot_pulse_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      lives_q        <= lives_d;
      phase_q        <= phase_d;
      hip_q          <= hip_d;
      hurt_cnt_q     <= hurt_cnt_d;
      death_cnt_q    <= death_cnt_d;
      cd_q           <= cd_d;
      hit_seen_q     <= hit_seen_d;
      phase_change_q <= phase_change_d;
      shoot_pulse_q  <= shoot_pulse_d;
    end
  end

  // fan widens symmetrically around the centre pair as phase rises
  always_comb begin
    fan_mask = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      fan_mask[i] = (i + int'(phase_q) >= CHANNELS / 2 - 1) &&
                    (i <= CHANNELS / 2 + int'(phase_q));
    end
  end

  assign lives_left   = lives_q;
  assign phase        = phase_q;
  assign phase_change = phase_change_q;
  assign shoot_pulse  = shoot_pulse_q;
  assign faded        = (state_q == S_HURT) & ~hurt_cnt_q[1];
  assign boss_dead    = (state_q == S_DYING) | (state_q == S_DEAD);
  assign deactivated  = (state_q == S_DEAD);

endmodule

// File: tb/tb_boss_phase_controller.sv
// Directed bench for boss_phase_controller: cadence, hurt blink,
// phase escalation, death sequence, enable hold and reset dominance.
module tb_boss_phase_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       sof = 1'b0;
  logic       hit = 1'b0;
  logic [4:0] lives_left;
  logic [1:0] phase;
  logic       phase_change;
  logic       shoot_pulse;
  logic [7:0] fan_mask;
  logic       faded;
  logic       boss_dead;
  logic       deactivated;

  int total = 0;
  int bad = 0;
  int sp_cyc = 0;
  int pc_cyc = 0;

  always #5 clk = ~clk;

  boss_phase_controller dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .startOfFrame (sof),
    .hit          (hit),
    .lives_left   (lives_left),
    .phase        (phase),
    .phase_change (phase_change),
    .shoot_pulse  (shoot_pulse),
    .fan_mask     (fan_mask),
    .faded        (faded),
    .boss_dead    (boss_dead),
    .deactivated  (deactivated)
  );

  always @(negedge clk) begin
    if (shoot_pulse) sp_cyc <= sp_cyc + 1;
    if (phase_change) pc_cyc <= pc_cyc + 1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic frame(input bit h, output bit sp, output bit pc);
    @(negedge clk);
    sof = 1'b1;
    hit = h;
    @(negedge clk);
    sof = 1'b0;
    sp = shoot_pulse;
    pc = phase_change;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    sof = 1'b0;
    hit = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_lives"}, lives_left, 12);
    chk({tag, "_phase"}, phase, 0);
    chk({tag, "_pc"}, phase_change, 0);
    chk({tag, "_sp"}, shoot_pulse, 0);
    chk({tag, "_fan"}, fan_mask, 8'h18);
    chk({tag, "_faded"}, faded, 0);
    chk({tag, "_dead"}, boss_dead, 0);
    chk({tag, "_deact"}, deactivated, 0);
  endtask

  initial begin
    bit sp;
    bit pc;
    int base_sp;
    int base_pc;
    int n;
    int exp_ph;
    logic [7:0] fan_tab [3] = '{8'h18, 8'h3C, 8'h7E};
    bit blink [10] = '{1, 0, 0, 1, 1, 0, 0, 1, 1, 0};
    int acc [12] = '{21, 32, 43, 54, 65, 76, 87, 98,
                     181, 192, 203, 214};

    do_reset();
    chk_reset_vals("rst");

    // cadence with no hits
    enable = 1'b1;
    base_sp = sp_cyc;
    for (int f = 1; f <= 200; f++) begin
      frame(1'b0, sp, pc);
      chk("t1_shot", sp, int'(f == 90 || f == 180));
    end
    chk("t1_width", sp_cyc - base_sp, 2);
    chk("t1_fan", fan_mask, 8'h18);

    // disabled frames with hit held: nothing moves
    enable = 1'b0;
    for (int f = 1; f <= 50; f++) begin
      frame(1'b1, sp, pc);
      chk("t5_shot", sp, 0);
    end
    chk("t5_lives", lives_left, 12);
    chk("t5_faded", faded, 0);
    hit = 1'b0;
    enable = 1'b1;
    for (int f = 1; f <= 70; f++) begin
      frame(1'b0, sp, pc);
      chk("t5_resume", sp, int'(f == 70));
    end
    chk("t5_nohit", lives_left, 12);

    // long hit within one frame, then hurt blink
    repeat (500) begin
      @(negedge clk);
      hit = 1'b1;
    end
    @(negedge clk);
    hit = 1'b0;
    chk("t2_pre", lives_left, 12);
    frame(1'b0, sp, pc);
    chk("t2_lives", lives_left, 11);
    chk("t2_fade0", faded, 1);
    for (int k = 0; k < 10; k++) begin
      frame(1'b0, sp, pc);
      chk($sformatf("t2_fade%0d", k + 1), faded, int'(blink[k]));
    end
    repeat (3) frame(1'b0, sp, pc);
    chk("t2_once", lives_left, 11);
    chk("t2_active", faded, 0);

    // escalation and death
    do_reset();
    base_sp = sp_cyc;
    base_pc = pc_cyc;
    for (int f = 1; f <= 240; f++) begin
      frame((f >= 21 && f <= 98) || f >= 181, sp, pc);
      n = 0;
      foreach (acc[k]) if (acc[k] <= f) n++;
      exp_ph = (f >= 98) ? 2 : ((f >= 54) ? 1 : 0);
      chk($sformatf("t3_lives_f%0d", f), lives_left, 12 - n);
      chk($sformatf("t3_phase_f%0d", f), phase, exp_ph);
      chk($sformatf("t3_fan_f%0d", f), fan_mask, fan_tab[exp_ph]);
      chk($sformatf("t3_shot_f%0d", f), sp,
          int'(f == 90 || f == 150 || f == 180 || f == 210));
      chk($sformatf("t3_pchg_f%0d", f), pc, int'(f == 54 || f == 98));
      chk($sformatf("t3_dead_f%0d", f), boss_dead, int'(f >= 214));
      chk($sformatf("t3_deact_f%0d", f), deactivated, int'(f >= 224));
    end
    chk("t3_shots", sp_cyc - base_sp, 4);
    chk("t3_pchgs", pc_cyc - base_pc, 2);

    // reset during dying, coincident with a hit on a tick
    do_reset();
    for (int f = 1; f <= 125; f++) frame(1'b1, sp, pc);
    chk("t6_dying", boss_dead, 1);
    chk("t6_notyet", deactivated, 0);
    @(negedge clk);
    reset = 1'b1;
    sof = 1'b1;
    hit = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sof = 1'b0;
    hit = 1'b0;
    chk_reset_vals("t6");
    frame(1'b0, sp, pc);
    chk("t6_lost", lives_left, 12);
    chk("t6_faded", faded, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
